// File: rtl/seg_disp_pkg.sv
// Shared types and BCD helpers for the seven-segment display arbiter.
package seg_disp_pkg;

  typedef enum logic [1:0] {IDLE, OWN, GAP} arb_state_t;

  localparam int BCD_W  = 4;
  localparam int DIGITS = 4;
  localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

  function automatic logic [BCD_W-1:0] bcd_clamp(input logic [BCD_W-1:0] n);
    return (n > BCD_MAX) ? BCD_MAX : n;
  endfunction

endpackage

// File: rtl/seg_display_arbiter_rr_picker.sv
// Round-robin pick: first set request at or above ptr, wrapping modulo NUM_SRC.
module rr_picker #(
  parameter int NUM_SRC = 4
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [2:0]         ptr,
  output logic [2:0]         idx,
  output logic               found
);

  logic [2*NUM_SRC-1:0] dbl;
  logic [NUM_SRC-1:0]   rot;
  logic [2:0]           k;
  int                   s;

  // Rotating a doubled vector puts the pointer's source at bit 0.
  assign dbl = {req, req};
  assign rot = NUM_SRC'(dbl >> ptr);

  always_comb begin
    k     = '0;
    found = 1'b0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (rot[i]) begin
        k     = 3'(i);
        found = 1'b1;
      end
    end
  end

  always_comb begin
    s = int'(ptr) + int'(k);
    if (s >= NUM_SRC) s = s - NUM_SRC;
    idx = 3'(s);
  end

endmodule

// File: rtl/seg_display_arbiter.sv
// Round-robin owner of the shared 4-digit display with minimum hold time.
// Optional SRC0_PREEMPT_EN: source 0 preempts any other owner on its request edge.
module seg_display_arbiter
  import seg_disp_pkg::*;
#(
  parameter int NUM_SRC    = 4,
  parameter int TICK_DIV   = 50000000,
  parameter int HOLD_TICKS = 3
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [NUM_SRC-1:0]     req,
  input  logic [16*NUM_SRC-1:0]  bcd_in,
  output logic [NUM_SRC-1:0]     grant,
  output logic [2:0]             owner,
  output logic                   active,
  output logic [3:0]             units,
  output logic [3:0]             tens,
  output logic [3:0]             hundreds,
  output logic [3:0]             thousands,
  output logic                   bcd_err
);

  localparam int PW    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int HW    = $clog2(HOLD_TICKS + 1);
  localparam int SLOTS = 8;
  localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);
  localparam logic [HW-1:0] HOLD_MAX  = HW'(HOLD_TICKS);

  arb_state_t                          state;
  logic [2:0]                          rr_ptr, pick_idx;
  logic                                pick_found;
  logic [PW-1:0]                       presc;
  logic [HW-1:0]                       hold_cnt, hold_nxt;
  logic                                tick, other_req, release_own, hold_exit;
  logic                                preempt, force_q;
  logic [SLOTS-1:0]                    req_ext;
  logic [SLOTS-1:0][DIGITS*BCD_W-1:0]  bcd_arr;
  logic [DIGITS-1:0][BCD_W-1:0]        sel, sel_clamp, dig_q;
  logic                                sel_bad;

  // Pad the per-source vectors to 8 slots so a 3-bit owner indexes them cleanly.
  for (genvar g = 0; g < SLOTS; g++) begin : g_slot
    if (g < NUM_SRC) begin : g_src
      assign bcd_arr[g] = bcd_in[16*g +: 16];
    end else begin : g_pad
      assign bcd_arr[g] = '0;
    end
  end

  assign req_ext = SLOTS'(req);
  assign sel     = bcd_arr[owner];

  always_comb begin
    sel_clamp = '0;
    sel_bad   = 1'b0;
    for (int d = 0; d < DIGITS; d++) begin
      sel_clamp[d] = bcd_clamp(sel[d]);
      if (sel[d] > BCD_MAX) sel_bad = 1'b1;
    end
  end

  assign tick        = (presc == TICK_LAST);
  assign hold_nxt    = (tick && hold_cnt != HOLD_MAX) ? hold_cnt + HW'(1) : hold_cnt;
  assign other_req   = |(req & ~grant);
  assign release_own = !req_ext[owner];
  // Expiry is judged on the post-tick count so the owner gets exactly HOLD_TICKS ticks.
  assign hold_exit   = (hold_nxt == HOLD_MAX) && other_req;

  rr_picker #(.NUM_SRC(NUM_SRC)) u_pick (
    .req   (req),
    .ptr   (rr_ptr),
    .idx   (pick_idx),
    .found (pick_found)
  );

  function automatic logic [2:0] ptr_after(input logic [2:0] idx);
    return (int'(idx) == NUM_SRC - 1) ? 3'd0 : idx + 3'd1;
  endfunction

`ifdef SRC0_PREEMPT_EN
  logic req0_q;

  always_ff @(posedge CLK) begin
    if (RST) req0_q <= 1'b0;
    else     req0_q <= req[0];
  end

  assign preempt = (state == OWN) && (owner != 3'd0) && req[0] && !req0_q;
`else
  assign preempt = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= IDLE;
      grant    <= '0;
      owner    <= '0;
      active   <= 1'b0;
      dig_q    <= '0;
      bcd_err  <= 1'b0;
      rr_ptr   <= '0;
      presc    <= '0;
      hold_cnt <= '0;
      force_q  <= 1'b0;
    end else begin
      bcd_err <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_found) begin
            owner    <= pick_idx;
            grant    <= NUM_SRC'(1) << pick_idx;
            active   <= 1'b1;
            rr_ptr   <= ptr_after(pick_idx);
            presc    <= '0;
            hold_cnt <= '0;
            state    <= OWN;
          end
        end
        OWN: begin
          dig_q    <= sel_clamp;
          bcd_err  <= sel_bad;
          presc    <= tick ? '0 : presc + PW'(1);
          hold_cnt <= hold_nxt;
          if (release_own || preempt || hold_exit) begin
            grant   <= '0;
            active  <= 1'b0;
            force_q <= preempt;
            state   <= GAP;
          end
        end
        GAP: begin
          force_q  <= 1'b0;
          presc    <= '0;
          hold_cnt <= '0;
          // A forced pick of source 0 leaves the round-robin pointer alone.
          if (force_q && req[0]) begin
            owner  <= 3'd0;
            grant  <= NUM_SRC'(1);
            active <= 1'b1;
            state  <= OWN;
          end else if (pick_found) begin
            owner  <= pick_idx;
            grant  <= NUM_SRC'(1) << pick_idx;
            active <= 1'b1;
            rr_ptr <= ptr_after(pick_idx);
            state  <= OWN;
          end else begin
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign units     = dig_q[0];
  assign tens      = dig_q[1];
  assign hundreds  = dig_q[2];
  assign thousands = dig_q[3];

endmodule

// File: tb/tb_seg_display_arbiter.sv
// Scoreboard bench: reference model pushes expected outputs, a monitor pops and compares.
module tb_seg_display_arbiter;

  localparam int N  = 4;
  localparam int TD = 4;
  localparam int HT = 2;

  logic              CLK = 1'b0;
  logic              RST = 1'b1;
  logic [N-1:0]      req = '0;
  logic [16*N-1:0]   bcd_in = '0;
  logic [N-1:0]      grant;
  logic [2:0]        owner;
  logic              active;
  logic [3:0]        units, tens, hundreds, thousands;
  logic              bcd_err;

  always #5 CLK = ~CLK;

  seg_display_arbiter #(.NUM_SRC(N), .TICK_DIV(TD), .HOLD_TICKS(HT)) dut (
    .CLK(CLK), .RST(RST), .req(req), .bcd_in(bcd_in),
    .grant(grant), .owner(owner), .active(active),
    .units(units), .tens(tens), .hundreds(hundreds), .thousands(thousands),
    .bcd_err(bcd_err)
  );

  typedef struct packed {
    logic [N-1:0] grant;
    logic [2:0]   owner;
    logic         active;
    logic [15:0]  digits;
    logic         err;
  } obs_t;

  obs_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Reference model state: who owns the display and for how many cycles.
  bit          m_own, m_err, m_prev0, m_force;
  int          m_owner, m_ptr, m_elapsed;
  logic [3:0]  m_dig[4];
  logic [15:0] bcd_v[N];

  function automatic logic [3:0] clamp9(input logic [3:0] n);
    return (n > 4'd9) ? 4'd9 : n;
  endfunction

  task automatic model_step(input bit rst);
    bit          rel, others, expired, pre, force_now, got;
    logic [15:0] v;
    int          pick;
    if (rst) begin
      m_own = 0; m_err = 0; m_prev0 = 0; m_force = 0;
      m_owner = 0; m_ptr = 0; m_elapsed = 0;
      for (int d = 0; d < 4; d++) m_dig[d] = 4'd0;
      return;
    end
    if (m_own) begin
      v = bcd_v[m_owner];
      m_err = 0;
      for (int d = 0; d < 4; d++) begin
        if (v[4*d +: 4] > 4'd9) m_err = 1;
        m_dig[d] = clamp9(v[4*d +: 4]);
      end
      rel     = !req[m_owner];
      others  = (req & ~(N'(1) << m_owner)) != '0;
      expired = (m_elapsed + 1) >= TD * HT;
      pre     = 0;
`ifdef SRC0_PREEMPT_EN
      pre = req[0] && !m_prev0 && (m_owner != 0);
`endif
      if (rel || pre || (expired && others)) begin
        m_own   = 0;
        m_force = pre;
      end else begin
        m_elapsed++;
      end
    end else begin
      m_err     = 0;
      force_now = m_force;
      m_force   = 0;
      if (force_now && req[0]) begin
        m_owner = 0; m_own = 1; m_elapsed = 0;
      end else begin
        got = 0; pick = 0;
        for (int i = 0; i < N; i++) begin
          if (!got && req[(m_ptr + i) % N]) begin
            got = 1; pick = (m_ptr + i) % N;
          end
        end
        if (got) begin
          m_owner = pick; m_own = 1; m_elapsed = 0;
          m_ptr = (pick + 1) % N;
        end
      end
    end
    m_prev0 = req[0];
  endtask

  task automatic apply(input logic [N-1:0] r, input bit rst);
    obs_t e;
    @(negedge CLK);
    #1;
    req = r;
    RST = rst;
    for (int i = 0; i < N; i++) bcd_in[16*i +: 16] = bcd_v[i];
    model_step(rst);
    e.grant  = m_own ? (N'(1) << m_owner) : '0;
    e.owner  = 3'(m_owner);
    e.active = m_own;
    e.digits = {m_dig[3], m_dig[2], m_dig[1], m_dig[0]};
    e.err    = m_err;
    exp_q.push_back(e);
  endtask

  task automatic hold_req(input logic [N-1:0] r, input int cycles);
    for (int c = 0; c < cycles; c++) apply(r, 1'b0);
  endtask

  // Monitor: pops one expectation per cycle once stimulus is flowing.
  initial begin
    obs_t a, e;
    forever begin
      @(negedge CLK);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a.grant  = grant;
        a.owner  = owner;
        a.active = active;
        a.digits = {thousands, hundreds, tens, units};
        a.err    = bcd_err;
        vectors++;
        if (a !== e) begin
          miscompares++;
          $display("FAIL outputs @%0t: got grant=%b owner=%0d active=%b digits=%h err=%b, want grant=%b owner=%0d active=%b digits=%h err=%b",
                   $time, a.grant, a.owner, a.active, a.digits, a.err,
                   e.grant, e.owner, e.active, e.digits, e.err);
        end
      end
    end
  end

  initial begin
    logic [N-1:0] r;
    bcd_v[0] = 16'h1234; bcd_v[1] = 16'h5678; bcd_v[2] = 16'h0917; bcd_v[3] = 16'h4321;

    apply('0, 1'b1);
    apply('0, 1'b1);
    hold_req(4'b0001, 4);           // single requester owns, digits follow
    hold_req(4'b0101, 14);          // hold expiry hands over to src2
    hold_req(4'b1100, 2);
    hold_req(4'b1000, 4);           // src2 release hands straight to src3
    hold_req(4'b1111, 45);          // full rotation with one-cycle gaps
    apply('0, 1'b1);
    bcd_v[1] = 16'h9A05;
    hold_req(4'b0010, 6);           // clamped digits and error pulses
    apply(4'b0010, 1'b1);           // reset while owning
    hold_req(4'b0010, 4);
    hold_req(4'b0011, 4);           // src0 request while src1 owns
    hold_req(4'b0000, 3);

    r = '0;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 11) == 0) r[i] = ~r[i];
        bcd_v[i] = {4'($urandom_range(0, 11)), 4'($urandom_range(0, 11)),
                    4'($urandom_range(0, 11)), 4'($urandom_range(0, 11))};
      end
      apply(r, ($urandom_range(0, 399) == 0));
    end

    @(negedge CLK);
    @(negedge CLK);
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/seg_display_arbiter.md
Name: seg_display_arbiter

Overview:
- Round-robin arbiter that shares the single 4-digit seven-segment display between NUM_SRC requesters.
- Requesters include the up/down BCD counter, a status/message source and a debug source. Each requester presents a 16-bit packed BCD value plus a request.
- The block grants one owner at a time, with a minimum hold time measured in prescaled ticks. It registers the owner's digits onto units/tens/hundreds/thousands, which feed display_7_seg.

Parameters:
- NUM_SRC, 4, number of requesters (2..8).
- TICK_DIV, 50000000, CLK cycles per hold tick (1 Hz at 50 MHz).
- HOLD_TICKS, 3, minimum ticks an owner keeps the display when others are waiting (>=1).

Ports:
- CLK  in  1  system clock.
- RST  in  1  reset: synchronous, active-high.
- req  in  NUM_SRC  request per source; level-sensitive; held while the source wants the display.
- bcd_in  in  16*NUM_SRC  per-source BCD value; source i is at bits [16i+15:16i], thousands in the top nibble.
- grant  out  NUM_SRC  one-hot current owner; all-zero when nobody owns the display.
- owner  out  3  index of the current or last owner.
- active  out  1  high while the display shows a granted source.
- units, tens, hundreds, thousands  out  4 each  registered digits to display_7_seg.
- bcd_err  out  1  one-cycle pulse when an owner nibble is greater than 9.

Behaviour:
- Reset (RST sampled high at a CLK edge):
  - state IDLE; grant 0; owner 0; active 0; all digits 0; bcd_err 0.
  - Internal state cleared: rr pointer 0, prescaler 0, hold_cnt 0.
  - Reset applies in any state and dominates every other event.
- States: IDLE, OWN, GAP.
- IDLE:
  - grant 0, active 0, digits hold their last value.
  - If any req bit is high at edge k: owner <= rr pick, grant <= onehot(owner), state <= OWN, all at edge k.
  - The grant is therefore visible the cycle after req is sampled.
- rr pick: first set req bit searching from pointer upward, wrapping modulo NUM_SRC. The pointer is (last owner + 1) mod NUM_SRC.
- On entry to OWN: prescaler <= 0, hold_cnt <= 0.
- OWN:
  - Every cycle, digits <= owner's bcd_in slice; the output follows the input with 1-cycle latency. active is 1.
  - Any digit greater than 9 is replaced by 9 and bcd_err pulses in that cycle.
  - prescaler counts 0..TICK_DIV-1 and wraps; tick fires when it equals TICK_DIV-1.
  - On tick: hold_cnt increments, saturating at HOLD_TICKS.
- OWN exit (to GAP), priority order:
  1. req[owner]=0: immediate release, regardless of hold_cnt.
  2. hold_cnt==HOLD_TICKS and any other req bit is high.
  - If neither applies, the owner keeps the display indefinitely.
- GAP:
  - Lasts exactly one cycle: grant 0, active 0, digits frozen. This gives a break-before-make, so two grant bits are never high together.
  - Next edge: if any req is high, OWN with the rr pick (pointer = previous owner + 1); otherwise IDLE.
  - The previous owner is eligible again only if no other source requests.
- Simultaneous events:
  - An owner release and a hold expiry in the same cycle is treated as a release.
  - Requests arriving during GAP are included in the pick.
- Widths: prescaler is $clog2(TICK_DIV) bits; hold_cnt is $clog2(HOLD_TICKS+1) bits. Neither wraps past its limit.

Optional Feature:
- SRC0_PREEMPT_EN defined:
  - Source 0 is high priority. If req[0] rises while another source owns the display, go to GAP immediately, ignoring hold_cnt.
  - The next pick is forced to 0. The rr pointer is unchanged by a forced pick.
- Undefined: source 0 is arbitrated purely round-robin like the others.

Decomposition:
- Package seg_disp_pkg:
  - State enum (IDLE, OWN, GAP).
  - BCD_W=4, DIGITS=4, BCD_MAX=9.
  - A function that clamps a nibble to BCD_MAX.
- One sub-module: rr_picker.
  - Combinational; inputs req and pointer; outputs index and found.
  - Instantiated once; also used for the GAP-exit pick.

Test Plan:
All scenarios use NUM_SRC=4, TICK_DIV=4, HOLD_TICKS=2.
1. Reset, then req=0001 with bcd_in[0]=16'h1234 → grant=0001 one cycle later; digits 4,3,2,1 one cycle after that; active=1.
2. Src0 owns; req=0101 held → src0 keeps the display for exactly 8 cycles of OWN; then 1 GAP cycle with grant=0; then grant=0100.
3. Owner src2 drops req after 2 cycles while req[3]=1 → GAP on the next cycle, then grant=1000 without waiting for hold.
4. req=1111 held → grant order 0001, 0010, 0100, 1000, 0001; each owner held 8 cycles; one GAP cycle between owners; grant is never multi-hot.
5. Owner presents 16'h9A05 → digits 5,0,9,9; bcd_err pulses once per cycle while the value is presented.
6. RST asserted mid-OWN → next cycle grant=0, digits=0, state IDLE. With SRC0_PREEMPT_EN, while src1 owns, req[0] rising → GAP next cycle, then grant=0001.
